target_scheduler: RTL and testbench

- Sequences the whack-a-target play field while a round is running.
- Picks a pseudo-random lit target and times its display window in game ticks.
- Detects the player's button hit or a miss, and emits the `player_scored` pulse consumed by the game FSM's score logic.
- Sits between the debounced button inputs, the LED driver and the game FSM; it is slaved to `game_active`.

---
 rtl/target_scheduler_if.sv | 12 +
 rtl/target_scheduler.sv | 99 +++++++++
 tb/tb_target_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/target_scheduler_if.sv
// target_scheduler_if: play-field bundle between game FSM/buttons (master) and the target scheduler (slave)
interface target_scheduler_if #(parameter int NUM_TARGETS = 4);
  logic game_active;
  logic tick;
  logic [NUM_TARGETS-1:0] btn;
  logic [NUM_TARGETS-1:0] target_onehot;
  logic player_scored;
  logic target_missed;
  logic wrong_press;
  modport master (output game_active, tick, btn, input target_onehot, player_scored, target_missed, wrong_press);
  modport slave (input game_active, tick, btn, output target_onehot, player_scored, target_missed, wrong_press);
endinterface

// File: rtl/target_scheduler.sv
// target_scheduler: picks a pseudo-random target, times its show window and scores hits/misses.
// Optional TARGET_SPEEDUP_EN shrinks the show window by one tick every 4 hits.
module target_scheduler #(
  parameter int NUM_TARGETS = 4,
  parameter int SHOW_TICKS = 8,
  parameter int GAP_TICKS = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MIN_SHOW_TICKS = 3
) (
  input logic clkIn,
  input logic reset,
  target_scheduler_if.slave bus
);
  localparam int W = $clog2(NUM_TARGETS);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, PICK, SHOW, GAP} state_t;
  state_t state;
  logic [15:0] lfsr, lfsr_n;
  logic [W-1:0] prev, idx_raw, idx;
  logic [7:0] cnt, cnt_n, window;
  logic [NUM_TARGETS-1:0] btn_q, btn_qq, rise;
  logic hit, wrong;
  assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign idx_raw = lfsr_n[W-1:0];
  assign idx = (idx_raw == prev) ? idx_raw + W'(1) : idx_raw;
  assign cnt_n = (bus.tick && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  assign hit = rise == bus.target_onehot;
  assign wrong = |(rise & ~bus.target_onehot);
`ifdef TARGET_SPEEDUP_EN
  logic [1:0] hits;
  logic [7:0] win_q;
  assign window = win_q;
  always_ff @(posedge clkIn) begin
    if (reset || !bus.game_active) begin
      hits <= '0;
      win_q <= 8'(SHOW_TICKS);
    end else if (state == SHOW && hit) begin
      hits <= hits + 2'd1;
      if (hits == 2'd3 && win_q > 8'(MIN_SHOW_TICKS)) win_q <= win_q - 8'd1;
    end
  end
`else
  assign window = 8'(SHOW_TICKS > MIN_SHOW_TICKS ? SHOW_TICKS : MIN_SHOW_TICKS);
`endif
  // Buttons pass two flops before the edge is registered, so held-through-reset presses never count
  always_ff @(posedge clkIn) begin
    btn_q <= bus.btn;
    btn_qq <= btn_q;
    rise <= btn_q & ~btn_qq;
    bus.player_scored <= 1'b0;
    bus.target_missed <= 1'b0;
    bus.wrong_press <= 1'b0;
    if (reset) begin
      state <= IDLE;
      bus.target_onehot <= '0;
      cnt <= '0;
      lfsr <= SEED;
      prev <= '0;
      btn_q <= '1;
      btn_qq <= '1;
      rise <= '0;
    end else if (!bus.game_active) begin
      state <= IDLE;
      bus.target_onehot <= '0;
    end else begin
      case (state)
        IDLE: state <= PICK;
        PICK: begin
          lfsr <= lfsr_n;
          prev <= idx;
          bus.target_onehot <= NUM_TARGETS'(1) << idx;
          cnt <= '0;
          state <= SHOW;
        end
        SHOW: begin
          if (hit) begin
            bus.player_scored <= 1'b1;
            bus.target_onehot <= '0;
            cnt <= '0;
            state <= GAP;
          end else begin
            bus.wrong_press <= wrong;
            cnt <= cnt_n;
            if (bus.tick && cnt_n >= window) begin
              bus.target_missed <= 1'b1;
              bus.target_onehot <= '0;
              cnt <= '0;
              state <= GAP;
            end
          end
        end
        GAP: begin
          cnt <= (cnt_n >= 8'(GAP_TICKS)) ? 8'd0 : cnt_n;
          state <= (cnt_n >= 8'(GAP_TICKS)) ? PICK : GAP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_target_scheduler.sv
// tb_target_scheduler: randomized play sessions; expected events queued by a transaction-level model, checked by a monitor
module tb_target_scheduler;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  target_scheduler_if #(.NUM_TARGETS(4)) bus();
  target_scheduler dut (.clkIn(clk), .reset(rst), .bus(bus));
  typedef struct packed { int cyc; logic sc; logic ms; logic wp; logic [3:0] oh; } ev_t;
  ev_t q[$];
  ev_t act, exp_e;
  int now = 0, checks = 0, fails = 0;
  bit mon_en = 0;
  logic [3:0] prev_oh = 0, last_lit = 0;
  int lfsr, prev_idx, hits, lit_idx;
  always @(negedge clk) begin
    if (mon_en && (bus.player_scored || bus.target_missed || bus.wrong_press || bus.target_onehot != prev_oh)) begin
      act = '{now, bus.player_scored, bus.target_missed, bus.wrong_press, bus.target_onehot};
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got sc=%b ms=%b wp=%b oh=%b, required no event", now, act.sc, act.ms, act.wp, act.oh);
      end else begin
        exp_e = q.pop_front();
        if (act != exp_e) begin
          fails++;
          $display("FAIL event got cyc=%0d sc=%b ms=%b wp=%b oh=%b, required cyc=%0d sc=%b ms=%b wp=%b oh=%b",
                   act.cyc, act.sc, act.ms, act.wp, act.oh, exp_e.cyc, exp_e.sc, exp_e.ms, exp_e.wp, exp_e.oh);
        end
      end
      if (bus.target_onehot != 0 && bus.target_onehot != prev_oh) begin
        checks++;
        if ($countones(bus.target_onehot) != 1 || bus.target_onehot == last_lit) begin
          fails++;
          $display("FAIL lit_norepeat cyc=%0d got oh=%b, required one-hot and not %b", now, bus.target_onehot, last_lit);
        end
        last_lit = bus.target_onehot;
      end
    end
    prev_oh = bus.target_onehot;
  end
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", n, got, want);
    end
  endtask
  task automatic cyc_do(input logic t);
    bus.tick = t;
    @(posedge clk);
    now++;
    #1 bus.tick = 0;
  endtask
  task automatic push(input int c, input logic sc, input logic ms, input logic wp, input logic [3:0] oh);
    q.push_back('{c, sc, ms, wp, oh});
  endtask
  function automatic int win();
`ifdef TARGET_SPEEDUP_EN
    return (8 - hits / 4 < 3) ? 3 : 8 - hits / 4;
`else
    return 8;
`endif
  endfunction
  function automatic int pick();
    int fb = ((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1;
    int idx;
    lfsr = ((lfsr << 1) | fb) & 'hFFFF;
    idx = lfsr % 4;
    if (idx == prev_idx) idx = (idx + 1) % 4;
    prev_idx = idx;
    return idx;
  endfunction
  task automatic start_round();
    bus.game_active = 1;
    cyc_do(0);
    lit_idx = pick();
    push(now + 1, 0, 0, 0, 4'(1 << lit_idx));
    cyc_do(0);
  endtask
  task automatic gap();
    for (int j = 0; j < 2; j++) begin
      repeat ($urandom_range(0, 2)) cyc_do(0);
      cyc_do(1);
    end
    lit_idx = pick();
    push(now + 1, 0, 0, 0, 4'(1 << lit_idx));
    cyc_do(0);
  endtask
  // mode 0: play normally, 1: drop game_active, 2: drop game_active as a hit lands
  task automatic do_target(input int mode);
    logic [3:0] lit = 4'(1 << lit_idx);
    logic [3:0] bad;
    int w = win();
    int nt;
    bus.btn = 0;
    cyc_do(0);
    if (mode == 0 && $urandom_range(0, 2) == 0) begin
      do bad = 4'($urandom_range(1, 15)); while ((bad & ~lit) == 0);
      bus.btn = bad;
      cyc_do(0);
      cyc_do(0);
      push(now + 1, 0, 0, 1, lit);
      cyc_do(0);
      bus.btn = 0;
      cyc_do(0);
      cyc_do(0);
    end
    nt = $urandom_range(0, w - 1);
    for (int i = 0; i < nt; i++) begin
      cyc_do(1);
      if ($urandom_range(0, 1) == 1) cyc_do(0);
    end
    if (mode == 0 && $urandom_range(0, 1) == 1) begin
      bus.btn = lit;
      cyc_do(0);
      cyc_do(0);
      push(now + 1, 1, 0, 0, 0);
      cyc_do(1'($urandom_range(0, 1)));
      hits++;
      bus.btn = 0;
      gap();
    end else if (mode == 0) begin
      for (int i = nt; i < w; i++) begin
        if ($urandom_range(0, 1) == 1) cyc_do(0);
        if (i == w - 1) push(now + 1, 0, 1, 0, 0);
        cyc_do(1);
      end
      gap();
    end else begin
      if (mode == 2) begin
        bus.btn = lit;
        cyc_do(0);
        cyc_do(0);
      end
      bus.game_active = 0;
      push(now + 1, 0, 0, 0, 0);
      cyc_do(0);
      hits = 0;
      bus.btn = 0;
      cyc_do(0);
      cyc_do(0);
      start_round();
    end
  endtask
  initial begin
    rst = 1;
    bus.game_active = 0;
    bus.tick = 0;
    bus.btn = 4'hF;
    lfsr = 'hACE1;
    prev_idx = 0;
    hits = 0;
    repeat (3) cyc_do(0);
    chk("reset_onehot", int'(bus.target_onehot), 0);
    chk("reset_scored", int'(bus.player_scored), 0);
    chk("reset_missed", int'(bus.target_missed), 0);
    chk("reset_wrong", int'(bus.wrong_press), 0);
    mon_en = 1;
    rst = 0;
    cyc_do(0);
    start_round();
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        bus.btn = 0;
        rst = 1;
        bus.game_active = 0;
        push(now + 1, 0, 0, 0, 0);
        cyc_do(0);
        cyc_do(0);
        rst = 0;
        lfsr = 'hACE1;
        prev_idx = 0;
        hits = 0;
        last_lit = 0;
        cyc_do(0);
        start_round();
      end
      do_target((n % 37 == 36) ? 1 : (n % 53 == 52) ? 2 : 0);
    end
    bus.game_active = 0;
    push(now + 1, 0, 0, 0, 0);
    repeat (4) cyc_do(0);
    chk("scoreboard_drain_pending", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
